// File: rtl/tracer_axi_pkg.sv
// tracer_axi_pkg: AXI constants, writer FSM states and helpers shared by the trace burst writer.
package tracer_axi_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int unsigned PAGE_BYTES = 4096;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  function automatic logic [31:0] min2(input logic [31:0] a, input logic [31:0] b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/trace_sync_fifo.sv
// trace_sync_fifo: first-word fall-through synchronous FIFO with occupancy count.
module trace_sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 32,
  localparam int AW = $clog2(Depth),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [Width-1:0] mem [Depth];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/axi_trace_burst_writer.sv
// axi_trace_burst_writer: drains buffered trace words into a device-memory ring as AXI4 INCR bursts,
// splitting bursts at the ring end and at 4 KB pages, and tracking outstanding B responses.
module axi_trace_burst_writer
  import tracer_axi_pkg::*;
#(
  parameter int AddressWidth = 32,
  parameter int DataWidth = 32,
  parameter int IDWidth = 1,
  parameter int MaxBurstLen = 16,
  parameter int MaxOutstandingWrites = 16,
  parameter int FifoDepth = 32,
  parameter int FlushTimeout = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AddressWidth-1:0] base_addr,
  input  logic [31:0]             buf_words,
  input  logic [DataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    busy,
  output logic [31:0]             words_written,
  output logic                    wrapped,
  output logic                    error,
  output logic [AddressWidth-1:0] awaddr,
  output logic [IDWidth-1:0]      awid,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DataWidth-1:0]    wdata,
  output logic [DataWidth/8-1:0]  wstrb,
  output logic [IDWidth-1:0]      wid,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [IDWidth-1:0]      bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);
  localparam int Bytes = DataWidth / 8;
  localparam int Size = $clog2(Bytes);
  localparam int CW = $clog2(FifoDepth) + 1;
  localparam int OW = $clog2(MaxOutstandingWrites + 1);
  localparam int IW = $clog2(FlushTimeout + 1);

  state_t state, next;
  logic [CW-1:0] fifo_count;
  logic [31:0] wr_ptr, ptr_sum, len_c, page_words;
  logic [OW-1:0] outstanding;
  logic [IW-1:0] idle_cnt;
  logic [8:0] len_q, beat_q;
  logic [AddressWidth-1:0] next_addr;
  logic flush_pending, push, has_words, start, aw_hs, w_hs, last_hs, b_hs, unused_bid;

  trace_sync_fifo #(.Width(DataWidth), .Depth(FifoDepth)) fifo (
    .clk(clk), .reset(reset), .push(push), .din(in_data),
    .pop(w_hs), .dout(wdata), .count(fifo_count)
  );

  assign in_ready = !reset && fifo_count < CW'(FifoDepth);
  assign push = in_valid && in_ready;
  assign has_words = fifo_count != '0;
  assign bready = !reset;
  assign busy = has_words || state != IDLE || outstanding != '0;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign last_hs = w_hs && wlast;
  assign b_hs = bvalid && bready;
  assign unused_bid = ^bid;

  // Burst length is capped by buffered words, burst limit, ring end and the 4 KB page.
  assign next_addr = base_addr + AddressWidth'(wr_ptr << Size);
  assign page_words = (32'(PAGE_BYTES) - 32'(next_addr[11:0])) >> Size;
  assign len_c = min2(min2(32'(fifo_count), 32'(MaxBurstLen)), min2(buf_words - wr_ptr, page_words));
  assign ptr_sum = wr_ptr + 32'(len_q);
  assign start = state == IDLE && outstanding < OW'(MaxOutstandingWrites) &&
                 (fifo_count >= CW'(MaxBurstLen) || (has_words && (flush_pending || idle_cnt == IW'(FlushTimeout))));

  assign awid = '0;
  assign wid = '0;
  assign awsize = 3'(Size);
  assign awburst = BURST_INCR;
  assign wstrb = '1;
  assign awlen = 8'(len_q - 9'd1);

  always_ff @(posedge clk) state <= reset ? IDLE : next;

  always_comb begin
    next = state;
    awvalid = state == ADDR;
    wvalid = state == DATA;
    wlast = wvalid && beat_q == 9'd1;
    if (start) next = ADDR;
    if (awvalid && awready) next = DATA;
    if (wlast && wready) next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      outstanding <= '0;
      idle_cnt <= '0;
      flush_pending <= 1'b0;
      words_written <= '0;
      wrapped <= 1'b0;
      error <= 1'b0;
      len_q <= '0;
      beat_q <= '0;
      awaddr <= '0;
    end else begin
      if (start) begin
        awaddr <= next_addr;
        len_q <= 9'(len_c);
        beat_q <= 9'(len_c);
      end
      if (w_hs) begin
        beat_q <= beat_q - 9'd1;
        words_written <= words_written + 32'd1;
      end
      if (last_hs) begin
        wr_ptr <= ptr_sum == buf_words ? '0 : ptr_sum;
        if (ptr_sum == buf_words) wrapped <= 1'b1;
      end
      outstanding <= outstanding + OW'(aw_hs) - OW'(b_hs);
      if (b_hs && bresp != RESP_OKAY) error <= 1'b1;
      flush_pending <= flush || (flush_pending && !(!has_words && state == IDLE && outstanding == '0));
      idle_cnt <= (push || start) ? '0 :
                  (state == IDLE && has_words && fifo_count < CW'(MaxBurstLen) && idle_cnt < IW'(FlushTimeout)) ?
                  idle_cnt + IW'(1) : idle_cnt;
    end
  end
endmodule

// File: tb/tb_axi_trace_burst_writer.sv
// tb_axi_trace_burst_writer: directed checks of burst formation, ring wrap, page split, B flow control and reset.
module tb_axi_trace_burst_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] base_addr = 32'h1000;
  logic [31:0] buf_words = 32'd1024;
  logic [31:0] in_data = '0;
  logic in_valid = 1'b0, flush = 1'b0, awready = 1'b1, wready = 1'b1, bvalid = 1'b0, b_en = 1'b1;
  logic [1:0] bresp = 2'b00;
  logic [0:0] bid = 1'b0;
  logic in_ready, busy, wrapped, error, awvalid, wlast, wvalid, bready;
  logic [31:0] words_written, awaddr, wdata;
  logic [0:0] awid, wid;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [3:0] wstrb;

  int passed = 0, fails = 0, total = 0, push_seq = 0;
  int aw_n = 0, nlast = 0, nb_hs = 0, beat = 0, data_bad = 0, w_seq = 0;
  logic [31:0] aw_addr_log [64];
  logic [7:0] aw_len_log [64];
  int last_log [64];

  axi_trace_burst_writer #(.MaxOutstandingWrites(2)) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .buf_words(buf_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .busy(busy), .words_written(words_written), .wrapped(wrapped), .error(error),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wid(wid),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  // Bus monitor: logs AW/W/B handshakes one half-cycle before the edge that completes them.
  always @(negedge clk) begin
    if (reset) begin
      nb_hs = nlast;
      beat = 0;
      w_seq = push_seq;
    end else begin
      if (awvalid && awready) begin
        aw_addr_log[aw_n] = awaddr;
        aw_len_log[aw_n] = awlen;
        aw_n++;
      end
      if (wvalid && wready) begin
        beat++;
        if (wdata !== 32'hA500_0000 + 32'(w_seq)) data_bad++;
        w_seq++;
        if (wlast) begin
          last_log[nlast] = beat;
          beat = 0;
          nlast++;
        end
      end
      if (bvalid && bready) nb_hs++;
    end
  end

  always @(posedge clk) begin
    #2;
    bvalid = !reset && b_en && nlast > nb_hs;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input string tag);
    int stalled = 0;
    for (int i = 0; i < n; i++) begin
      int g = 0;
      in_data = 32'hA500_0000 + 32'(push_seq);
      in_valid = 1'b1;
      while (!in_ready && g < 500) begin
        tick();
        g++;
      end
      if (g >= 500) stalled = 1;
      tick();
      push_seq++;
    end
    in_valid = 1'b0;
    chk(tag, 32'(stalled), 0);
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    tick();
    while (busy && g < 1000) begin
      tick();
      g++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int a0, l0, n;
    repeat (3) tick();
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_wlast", 32'(wlast), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_words", words_written, 0);
    chk("rst_wrapped", 32'(wrapped), 0);
    chk("rst_error", 32'(error), 0);
    reset = 1'b0;
    tick();
    chk("bready_run", 32'(bready), 1);
    chk("in_ready_run", 32'(in_ready), 1);

    // Full 16-word burst
    a0 = aw_n; l0 = nlast;
    push(16, "t1_push");
    wait_idle("t1_idle");
    chk("t1_aw_cnt", 32'(aw_n - a0), 1);
    chk("t1_addr", aw_addr_log[a0], 32'h1000);
    chk("t1_awlen", 32'(aw_len_log[a0]), 15);
    chk("t1_wlast_beat", 32'(last_log[l0]), 16);
    chk("t1_words", words_written, 16);
    chk("t1_awsize", 32'(awsize), 2);
    chk("t1_awburst", 32'(awburst), 1);
    chk("t1_wstrb", 32'(wstrb), 32'hF);

    // Partial burst forced by flush
    a0 = aw_n; l0 = nlast;
    push(5, "t2_push");
    pulse_flush();
    wait_idle("t2_idle");
    chk("t2_addr", aw_addr_log[a0], 32'h1040);
    chk("t2_awlen", 32'(aw_len_log[a0]), 4);
    chk("t2_wlast_beat", 32'(last_log[l0]), 5);
    chk("t2_words", words_written, 21);

    // Partial burst forced by idle timeout
    a0 = aw_n; l0 = nlast;
    push(5, "t3_push");
    n = 0;
    while (!awvalid && n < 200) begin
      tick();
      n++;
    end
    chk("t3_timeout_cycles", 32'(n), 65);
    wait_idle("t3_idle");
    chk("t3_addr", aw_addr_log[a0], 32'h1054);
    chk("t3_awlen", 32'(aw_len_log[a0]), 4);
    chk("t3_words", words_written, 26);

    // Ring wrap at buf_words=20
    buf_words = 32'd20;
    do_reset();
    chk("t4_wrapped_clear", 32'(wrapped), 0);
    a0 = aw_n;
    push(32, "t4_push");
    pulse_flush();
    wait_idle("t4_idle");
    chk("t4_aw_cnt", 32'(aw_n - a0), 3);
    chk("t4_addr0", aw_addr_log[a0], 32'h1000);
    chk("t4_len0", 32'(aw_len_log[a0]), 15);
    chk("t4_addr1", aw_addr_log[a0+1], 32'h1040);
    chk("t4_len1", 32'(aw_len_log[a0+1]), 3);
    chk("t4_addr2", aw_addr_log[a0+2], 32'h1000);
    chk("t4_len2", 32'(aw_len_log[a0+2]), 11);
    chk("t4_wrapped", 32'(wrapped), 1);
    chk("t4_words", words_written, 32);

    // 4 KB page split
    base_addr = 32'h0FF0;
    buf_words = 32'd64;
    do_reset();
    a0 = aw_n;
    push(16, "t5_push");
    pulse_flush();
    wait_idle("t5_idle");
    chk("t5_aw_cnt", 32'(aw_n - a0), 2);
    chk("t5_addr0", aw_addr_log[a0], 32'h0FF0);
    chk("t5_len0", 32'(aw_len_log[a0]), 3);
    chk("t5_addr1", aw_addr_log[a0+1], 32'h1000);
    chk("t5_len1", 32'(aw_len_log[a0+1]), 11);
    chk("t5_wrapped", 32'(wrapped), 0);

    // Outstanding limit of 2 with B withheld
    base_addr = 32'h1000;
    buf_words = 32'd1024;
    do_reset();
    b_en = 1'b0;
    a0 = aw_n;
    push(48, "t6_push");
    repeat (20) tick();
    chk("t6_aw_blocked_cnt", 32'(aw_n - a0), 2);
    chk("t6_awvalid_low", 32'(awvalid), 0);
    chk("t6_busy", 32'(busy), 1);
    b_en = 1'b1;
    l0 = nb_hs;
    n = 0;
    while (nb_hs == l0 && n < 50) begin
      tick();
      n++;
    end
    chk("t6_b_seen", 32'(nb_hs - l0), 1);
    n = 0;
    while (!awvalid && n < 50) begin
      tick();
      n++;
    end
    chk("t6_aw_after_b", 32'(n <= 2), 1);
    wait_idle("t6_idle");
    chk("t6_aw_cnt", 32'(aw_n - a0), 3);
    chk("t6_addr2", aw_addr_log[a0+2], 32'h1080);
    chk("t6_words", words_written, 48);

    // Error response is sticky
    bresp = 2'b10;
    push(16, "t7_push");
    wait_idle("t7_idle");
    bresp = 2'b00;
    chk("t7_error", 32'(error), 1);
    push(16, "t7_push_ok");
    wait_idle("t7_idle_ok");
    chk("t7_error_held", 32'(error), 1);

    // Reset during beat 3 abandons the burst
    push(16, "t8_push");
    n = 0;
    while (beat != 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t8_beat2_reached", 32'(beat), 2);
    reset = 1'b1;
    tick();
    chk("t8_awvalid", 32'(awvalid), 0);
    chk("t8_wvalid", 32'(wvalid), 0);
    chk("t8_wlast", 32'(wlast), 0);
    chk("t8_words", words_written, 0);
    chk("t8_error", 32'(error), 0);
    chk("t8_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();
    a0 = aw_n; l0 = nlast;
    push(16, "t8_push_after");
    wait_idle("t8_idle");
    chk("t8_aw_cnt", 32'(aw_n - a0), 1);
    chk("t8_addr", aw_addr_log[a0], 32'h1000);
    chk("t8_wlast_beat", 32'(last_log[l0]), 16);
    chk("t8_words_after", words_written, 16);
    chk("data_order", 32'(data_bad), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
